dmem_mmio_responder: RTL

//  Responder on the arm core's data-memory port: the memory end of the MemWrite/ALUResult/

---
 rtl/dmem_mmio_responder_pkg.sv | 28 ++
 rtl/dmem_mmio_responder_sync_fifo.sv | 53 +++++
 rtl/dmem_mmio_responder.sv | 98 +++++++++
 3 files changed

// File: rtl/dmem_mmio_responder_pkg.sv
// Shared definitions for the data-memory responder: MMIO register offsets and
// console status bit layout, mirrored by the software headers.
package dmem_mmio_responder_pkg;

  typedef enum logic [1:0] {
    OFF_CON_DATA = 2'd0,
    OFF_CON_STAT = 2'd1,
    OFF_CYCLES   = 2'd2,
    OFF_RSVD     = 2'd3
  } mmio_off_e;

  localparam int STAT_FULL_BIT  = 0;
  localparam int STAT_EMPTY_BIT = 1;
  localparam int STAT_OVF_BIT   = 2;
  localparam int STAT_COUNT_LSB = 8;

  function automatic logic [31:0] con_stat(input logic [7:0] count, input logic ovf,
                                           input logic empty, input logic full);
    logic [31:0] s;
    s = '0;
    s[STAT_FULL_BIT]            = full;
    s[STAT_EMPTY_BIT]           = empty;
    s[STAT_OVF_BIT]             = ovf;
    s[STAT_COUNT_LSB +: 8]      = count;
    return s;
  endfunction

endpackage

// File: rtl/dmem_mmio_responder_sync_fifo.sv
// Synchronous FIFO with show-ahead head output; a push into a full FIFO is
// still accepted when a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic             accept,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_pop;

  assign full   = (count == CW'(DEPTH));
  assign empty  = (count == '0);
  assign do_pop = pop && !empty;
  assign accept = push && (!full || do_pop);
  // Head is forced to zero while empty so stale storage never leaks out.
  assign rdata  = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (accept) mem[wr_ptr] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      case ({accept, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/dmem_mmio_responder.sv
// Data-memory responder for the single-cycle core: word RAM, console TX FIFO
// and a free-running cycle counter behind a 16-byte MMIO window.
module dmem_mmio_responder
  import dmem_mmio_responder_pkg::*;
#(
  parameter int          RAM_WORDS  = 64,
  parameter int          FIFO_DEPTH = 8,
  parameter logic [31:0] MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready
);

  localparam int          RAW       = $clog2(RAM_WORDS);
  localparam int          FCW       = $clog2(FIFO_DEPTH) + 1;
  localparam logic [31:0] RAM_BYTES = 32'(RAM_WORDS * 4);

  logic [31:0]    ram [RAM_WORDS];
  logic [31:0]    cycles;
  logic           ovf;
  logic           ram_sel, mmio_sel;
  mmio_off_e      off;
  logic [RAW-1:0] ram_idx;
  logic           ram_we, con_push, stat_we, cyc_we;
  logic           fifo_full, fifo_empty, fifo_accept;
  logic [FCW-1:0] fifo_count;
  logic [8:0]     cnt_ext;
  logic           unused_bits;

  assign ram_sel  = (ALUResult < RAM_BYTES);
  assign mmio_sel = (ALUResult[31:4] == MMIO_BASE[31:4]);
  assign off      = mmio_off_e'(ALUResult[3:2]);
  assign ram_idx  = ALUResult[RAW+1:2];

  assign ram_we   = MemWrite && ram_sel;
  assign con_push = MemWrite && mmio_sel && (off == OFF_CON_DATA);
  assign stat_we  = MemWrite && mmio_sel && (off == OFF_CON_STAT);
  assign cyc_we   = MemWrite && mmio_sel && (off == OFF_CYCLES);

  assign cnt_ext     = 9'(fifo_count);
  assign unused_bits = ^{ALUResult[1:0], cnt_ext[8]};

  // Console stream: tx_data is the FIFO head, valid whenever the FIFO is
  // non-empty; a byte transfers on a rising edge with tx_valid && tx_ready, and
  // tx_data holds steady while tx_valid is high and tx_ready is low.
  assign tx_valid = !fifo_empty;

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk    (clk),
    .reset  (reset),
    .push   (con_push),
    .pop    (tx_valid && tx_ready),
    .wdata  (WriteData[7:0]),
    .rdata  (tx_data),
    .full   (fifo_full),
    .empty  (fifo_empty),
    .accept (fifo_accept),
    .count  (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (ram_we) ram[ram_idx] <= WriteData;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycles <= '0;
      ovf    <= 1'b0;
    end else begin
      cycles <= cyc_we ? WriteData : cycles + 32'd1;
      // A dropped byte wins over a software clear in the same cycle.
      if (con_push && !fifo_accept)              ovf <= 1'b1;
      else if (stat_we && WriteData[STAT_OVF_BIT]) ovf <= 1'b0;
    end
  end

  always_comb begin
    ReadData = '0;
    if (ram_sel) begin
      ReadData = ram[ram_idx];
    end else if (mmio_sel) begin
      unique case (off)
        OFF_CON_DATA: ReadData = '0;
        OFF_CON_STAT: ReadData = con_stat(cnt_ext[7:0], ovf, fifo_empty, fifo_full);
        OFF_CYCLES:   ReadData = cycles;
        OFF_RSVD:     ReadData = '0;
      endcase
    end
  end

endmodule
